// File: rtl/nibble_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nibble_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/simple_adder.sv
// 4-bit ripple-carry adder slice, purely combinational.
module simple_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  // Ripple the carry bit by bit through the four full-adder cells.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/nibble_add_sequencer.sv
// Nibble-serial adder/subtractor: one 4-bit slice is reused over WIDTH/4
// cycles, with the inter-nibble carry held in a register.
module nibble_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBS = WIDTH / NIBBLE_W;
  localparam int KW   = (NIBS > 2) ? $clog2(NIBS) : 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [KW-1:0] KLAST = KW'(NIBS - 1);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8 || WIDTH > 64) begin : g_bad_width
      $error("nibble_add_sequencer: WIDTH must be a multiple of 4 in 8..64");
    end
  endgenerate

  state_t           state;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       slice_sum;
  logic             slice_cout;

  // Present the current nibble of each latched operand to the shared slice.
  always_comb begin
    a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
    b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
  end

  simple_adder u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Control FSM plus all datapath registers; every output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            k        <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          sum[k*NIBBLE_W +: NIBBLE_W] <= slice_sum;
          carry <= slice_cout;
          k     <= k + 1'b1;
          if (k == KLAST) begin
            cout      <= slice_cout;
            ovf       <= (a_q[MSB] == b_q[MSB]) && (slice_sum[3] != a_q[MSB]);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
